// File: rtl/lighting_ctrl_if.sv
// Setting-load handshake for lighting_ctrl: time code, user level and room
// size qualified by in_valid/in_ready.
interface lighting_ctrl_if;
  logic [3:0] tcode;
  logic [3:0] ulight;
  logic [3:0] lenght;
  logic       in_valid;
  logic       in_ready;

  modport master (output tcode, ulight, lenght, in_valid, input in_ready);
  modport slave  (input tcode, ulight, lenght, in_valid, output in_ready);
endinterface

// File: rtl/lighting_ctrl.sv
// Room lighting controller: ramps lamp count and window shade one step per
// RAMP_DIV cycles toward targets derived from time of day, user level and room size.
module lighting_ctrl #(
  parameter int unsigned NLAMP    = 16,
  parameter int unsigned RAMP_DIV = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  lighting_ctrl_if.slave               cfg,
  input  logic                         force_off,
  output logic [$clog2(NLAMP+1)-1:0]   lightnum,
  output logic [NLAMP-1:0]             lightstate,
  output logic [3:0]                   wshade,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned W  = $clog2(NLAMP+1);
  localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  light_q, light_d, light_step;
  logic [3:0]    shade_q, shade_d, shade_step;
  logic [W-1:0]  lamp_tgt_q, lamp_tgt_d;
  logic [3:0]    shade_tgt_q, shade_tgt_d;
  logic [PW-1:0] pre_q, pre_d;

  logic [3:0]    demand;
  logic [5:0]    lamp_raw;
  logic [W-1:0]  lamp_calc;
  logic [3:0]    shade_calc;

  // Product kept at 8 bits so the clamp sees the full value (up to 56).
  always_comb begin
    demand     = cfg.tcode[3] ? cfg.ulight : {1'b0, cfg.ulight[3:1]};
    lamp_raw   = 6'(({4'b0, demand} * {4'b0, cfg.lenght}) >> 2);
    lamp_calc  = ({26'b0, lamp_raw} > NLAMP) ? W'(NLAMP) : W'(lamp_raw);
    shade_calc = cfg.tcode[3] ? 4'd15 : 4'd15 - cfg.ulight;
  end

  always_comb begin
    light_step = light_q;
    if (light_q < lamp_tgt_q)      light_step = light_q + 1'b1;
    else if (light_q > lamp_tgt_q) light_step = light_q - 1'b1;
    shade_step = shade_q;
    if (shade_q < shade_tgt_q)      shade_step = shade_q + 1'b1;
    else if (shade_q > shade_tgt_q) shade_step = shade_q - 1'b1;
  end

  assign cfg.in_ready = (state_q == IDLE) && !force_off;

  always_comb begin
    state_d     = state_q;
    light_d     = light_q;
    shade_d     = shade_q;
    lamp_tgt_d  = lamp_tgt_q;
    shade_tgt_d = shade_tgt_q;
    pre_d       = pre_q;
    if (force_off) begin
      state_d = IDLE;
      light_d = '0;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg.in_valid) begin
            lamp_tgt_d  = lamp_calc;
            shade_tgt_d = shade_calc;
            pre_d       = '0;
            state_d     = (lamp_calc == light_q && shade_calc == shade_q) ? DONE : RAMP;
          end
        end
        RAMP: begin
          if (pre_q == PRE_LAST) begin
            pre_d   = '0;
            light_d = light_step;
            shade_d = shade_step;
            if (light_step == lamp_tgt_q && shade_step == shade_tgt_q) state_d = DONE;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      light_q     <= '0;
      shade_q     <= '0;
      lamp_tgt_q  <= '0;
      shade_tgt_q <= '0;
      pre_q       <= '0;
    end else begin
      state_q     <= state_d;
      light_q     <= light_d;
      shade_q     <= shade_d;
      lamp_tgt_q  <= lamp_tgt_d;
      shade_tgt_q <= shade_tgt_d;
      pre_q       <= pre_d;
    end
  end

  always_comb begin
    lightstate = '0;
    for (int unsigned i = 0; i < NLAMP; i++) lightstate[i] = (i < 32'(light_q));
  end

  assign lightnum = light_q;
  assign wshade   = shade_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule
